// File: rtl/usr_ctrl_pkg.sv
// usr_ctrl_pkg
//   Shared types and constants for the usr_ctrl command sequencer:
//   operation codes, FSM states, select encodings understood by usr,
//   and the fixed serialisation length.
package usr_ctrl_pkg;

  typedef enum logic [1:0] {
    SER_R = 2'b00,
    SER_L = 2'b01,
    ROT_R = 2'b10,
    ROT_L = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] USR_SEL_HOLD = 2'b00;
  localparam logic [1:0] USR_SEL_SHR  = 2'b01;
  localparam logic [1:0] USR_SEL_SHL  = 2'b10;
  localparam logic [1:0] USR_SEL_LOAD = 2'b11;

  localparam int SER_LEN = 4;

  // Serialising ops emit one bit per shift; rotations emit nothing.
  function automatic logic is_ser(input op_t op);
    return (op == SER_R) || (op == SER_L);
  endfunction

  // Right-moving ops shift toward bit 0.
  function automatic logic is_right(input op_t op);
    return (op == SER_R) || (op == ROT_R);
  endfunction

endpackage

// File: rtl/usr_ctrl_usr.sv
// usr
//   Universal shift register: hold, shift right, shift left, parallel load.
//   Ports:
//     clk      - clock, rising edge
//     clr      - synchronous active-high clear (q <= 0)
//     sel      - 00 hold, 01 shift right, 10 shift left, 11 load
//     par_in   - parallel load word
//     right_in - bit entering at the MSB on a right shift
//     left_in  - bit entering at the LSB on a left shift
//     q        - register contents
module usr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] par_in,
  input  logic             right_in,
  input  logic             left_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else begin
      case (sel)
        2'b01:   r_q <= {right_in, r_q[WIDTH-1:1]};
        2'b10:   r_q <= {r_q[WIDTH-2:0], left_in};
        2'b11:   r_q <= par_in;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/usr_ctrl.sv
// usr_ctrl
//   Command sequencer around usr. A command (op, data, count) is accepted
//   over a valid/ready handshake, loaded into usr, then shifted for a
//   counted number of cycles to serialise (LSB- or MSB-first) or rotate.
//   Ports:
//     clk       - clock, rising edge
//     clr       - synchronous active-high reset, shared with usr
//     cmd_valid - command presented
//     cmd_ready - controller idle and not in reset
//     cmd_op    - 00 SER_R, 01 SER_L, 10 ROT_R, 11 ROT_L
//     cmd_data  - word to load
//     cmd_cnt   - rotate count (ROT ops only)
//     ser_out   - serial bit (pre-shift LSB for SER_R, MSB for SER_L)
//     ser_valid - ser_out meaningful this cycle
//     done      - one-cycle completion pulse
//     result    - current usr contents
module usr_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           r_state;
  state_t           w_state_next;
  op_t              r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt_cmd;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_load_cnt;
  logic             w_accept;
  logic [1:0]       w_sel;
  logic             w_right_in;
  logic             w_left_in;
  logic [WIDTH-1:0] w_q;

  assign cmd_ready = (r_state == IDLE) && !clr;
  assign w_accept  = cmd_valid && cmd_ready;

  // Serialisation always runs the full word; rotations use the latched count.
  assign w_load_cnt = is_ser(r_op) ? CNT_W'(SER_LEN) : r_cnt_cmd;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= SER_R;
      r_data    <= '0;
      r_cnt_cmd <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_op      <= op_t'(cmd_op);
        r_data    <= cmd_data;
        r_cnt_cmd <= cmd_cnt;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sel        = USR_SEL_HOLD;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_sel        = USR_SEL_LOAD;
        w_cnt_next   = w_load_cnt;
        w_state_next = (w_load_cnt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        w_sel      = is_right(r_op) ? USR_SEL_SHR : USR_SEL_SHL;
        w_cnt_next = r_cnt - CNT_W'(1);
        // <= rather than == so a corrupted zero count cannot spin forever.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Rotations feed the outgoing bit back in; serialisation fills with zeros.
  assign w_right_in = (r_op == ROT_R) ? w_q[0] : 1'b0;
  assign w_left_in  = (r_op == ROT_L) ? w_q[WIDTH-1] : 1'b0;

  usr #(
    .WIDTH(WIDTH)
  ) u_usr (
    .clk     (clk),
    .clr     (clr),
    .sel     (w_sel),
    .par_in  (r_data),
    .right_in(w_right_in),
    .left_in (w_left_in),
    .q       (w_q)
  );

  assign ser_valid = (r_state == SHIFT) && is_ser(r_op);
  assign ser_out   = ser_valid ? ((r_op == SER_R) ? w_q[0] : w_q[WIDTH-1]) : 1'b0;
  assign done      = (r_state == DONE);
  assign result    = w_q;

endmodule

// File: tb/tb_usr_ctrl.sv
// tb_usr_ctrl
//   Self-checking bench for usr_ctrl: directed vector table, clear-abort and
//   back-pressure sequences, then randomized commands against a word-level
//   reference model.
module tb_usr_ctrl;

  logic       clk;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic       ser_out;
  logic       ser_valid;
  logic       done;
  logic [3:0] result;

  int n_cmp;
  int n_err;

  usr_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_cnt  (cmd_cnt),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] cnt;
    int         n;        // expected number of SHIFT cycles
    logic [3:0] bits;     // bits[i] = i-th serial bit emitted
    logic [3:0] res;      // result at done
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a serialisation emits the word bit by bit and leaves
  // zeros; a rotation by c is a rotation by c mod 4 of the word.
  task automatic model(input logic [1:0] op, input logic [3:0] d, input logic [2:0] c,
                       output int n, output logic [3:0] bits, output logic [3:0] res);
    logic [7:0] dd;
    int r;
    dd   = {d, d};
    r    = int'(c) % 4;
    bits = 4'b0000;
    case (op)
      2'b00: begin n = 4; for (int i = 0; i < 4; i++) bits[i] = d[i];     res = 4'b0000; end
      2'b01: begin n = 4; for (int i = 0; i < 4; i++) bits[i] = d[3 - i]; res = 4'b0000; end
      2'b10: begin n = int'(c); dd = dd >> r; res = dd[3:0]; end
      default: begin n = int'(c); dd = dd << r; res = dd[7:4]; end
    endcase
  endtask

  // Issue one command and check every cycle from LOAD through the return to IDLE.
  task automatic run_cmd(input string name, input vec_t v);
    int  waited;
    logic is_ser;
    is_ser = (v.op == 2'b00) || (v.op == 2'b01);
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({name, " ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    cmd_cnt   = v.cnt;
    @(negedge clk);                       // T+1: LOAD
    cmd_valid = 1'b0;
    chk({name, " load"}, {29'd0, cmd_ready, ser_valid, done}, 32'd0);
    for (int k = 0; k < v.n; k++) begin   // T+2 .. T+1+N: SHIFT
      @(negedge clk);
      chk({name, " shift"}, {29'd0, ser_valid, ser_out, done},
          {29'd0, is_ser, is_ser ? v.bits[k] : 1'b0, 1'b0});
    end
    @(negedge clk);                       // T+2+N: DONE
    chk({name, " done"}, {26'd0, done, ser_valid, result}, {26'd0, 1'b1, 1'b0, v.res});
    @(negedge clk);                       // T+3+N: IDLE again
    chk({name, " idle"}, {28'd0, done, cmd_ready, result[1:0] ^ v.res[1:0]}, {28'd0, 1'b0, 1'b1, 2'b00});
  endtask

  vec_t tbl [6];

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 4'h0;
    cmd_cnt = 3'd0;

    tbl[0] = '{op: 2'b00, data: 4'b1011, cnt: 3'd0, n: 4, bits: 4'b1011, res: 4'b0000};
    tbl[1] = '{op: 2'b01, data: 4'b1011, cnt: 3'd0, n: 4, bits: 4'b1101, res: 4'b0000};
    tbl[2] = '{op: 2'b10, data: 4'b0011, cnt: 3'd1, n: 1, bits: 4'b0000, res: 4'b1001};
    tbl[3] = '{op: 2'b10, data: 4'b0011, cnt: 3'd5, n: 5, bits: 4'b0000, res: 4'b1001};
    tbl[4] = '{op: 2'b11, data: 4'b0110, cnt: 3'd0, n: 0, bits: 4'b0000, res: 4'b0110};
    tbl[5] = '{op: 2'b11, data: 4'b0110, cnt: 3'd2, n: 2, bits: 4'b0000, res: 4'b1001};

    // Reset state, while clr is still asserted and after release.
    repeat (3) @(negedge clk);
    chk("reset outs", {25'd0, cmd_ready, ser_valid, ser_out, done, result}, 32'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("reset ready", {31'd0, cmd_ready}, 32'd1);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i]);
    end

    // Clear mid-command: SER_R 1111, clr sampled at the end of T+3.
    begin
      int done_seen;
      int sv_seen;
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b1111; cmd_cnt = 3'd0;
      @(negedge clk);                     // T+1
      cmd_valid = 1'b0;
      @(negedge clk);                     // T+2
      @(negedge clk);                     // T+3
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);                     // T+4
      chk("clr abort", {26'd0, cmd_ready, ser_valid, result}, {26'd0, 1'b1, 1'b0, 4'b0000});
      done_seen = 0;
      sv_seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (done) done_seen++;
        if (ser_valid) sv_seen++;
      end
      chk("clr no done", done_seen, 0);
      chk("clr no ser_valid", sv_seen, 0);
    end

    // Held cmd_valid: second command accepted exactly at T+3+N, done 4 later.
    begin
      int first_ready;
      int dones [$];
      int lowcnt;
      first_ready = -1;
      lowcnt = 0;
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b1011; cmd_cnt = 3'd0;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (k == 1) begin
          cmd_op = 2'b11; cmd_data = 4'b0110; cmd_cnt = 3'd2;
        end
        if (first_ready >= 0 && k == first_ready + 1) cmd_valid = 1'b0;
        if (cmd_ready && first_ready < 0) first_ready = k;
        if (first_ready < 0 && !cmd_ready) lowcnt++;
        if (done) begin
          dones.push_back(k);
          if (k == 11) chk("b2b result", {28'd0, result}, {28'd0, 4'b1001});
        end
      end
      cmd_valid = 1'b0;
      chk("b2b accept cycle", first_ready, 7);
      chk("b2b ready low", lowcnt, 6);
      chk("b2b done count", dones.size(), 2);
      if (dones.size() == 2) begin
        chk("b2b done1", dones[0], 6);
        chk("b2b done2", dones[1], 11);
      end
      @(negedge clk);
    end

    // Randomized commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.op   = 2'($urandom_range(0, 3));
      v.data = 4'($urandom_range(0, 15));
      v.cnt  = 3'($urandom_range(0, 7));
      model(v.op, v.data, v.cnt, v.n, v.bits, v.res);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd($sformatf("rnd%0d op%0d d%0h c%0d", i, v.op, v.data, v.cnt), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
